// File: rtl/spi_chain_pkg.sv
// Shared types and helpers for the SPI chain initiator.
package spi_chain_pkg;

    localparam int DEFAULT_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2,
        GAP   = 2'd3
    } state_t;

    // Cycles from handshake until o_ready is high again.
    function automatic int frame_cycles(input int data_w, input int clk_div, input int load_cyc);
        return data_w * 2 * clk_div + load_cyc + clk_div;
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// spi_clk divider: half-period counter with one-cycle rise/fall strobes.
// While en is low the counter and clock level are held at zero.
module spi_clk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic rise,
    output logic fall,
    output logic spi_clk
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] divcnt;
    logic             wrap;

    // Strobes are high in the cycle before spi_clk actually changes level.
    assign wrap = en && (divcnt == LAST);
    assign rise = wrap && !spi_clk;
    assign fall = wrap && spi_clk;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            divcnt  <= '0;
            spi_clk <= 1'b0;
        end else if (!en) begin
            divcnt  <= '0;
            spi_clk <= 1'b0;
        end else if (wrap) begin
            divcnt  <= '0;
            spi_clk <= ~spi_clk;
        end else begin
            divcnt  <= divcnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/spi_chain_tx.sv
// Serial initiator that shifts a word MSB first into the SPI chain and strobes load.
// Define SPI_CHAIN_TX_READBACK_EN to capture the chain's old contents from i_spi_miso.
module spi_chain_tx
    import spi_chain_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int CLK_DIV  = 4,
    parameter int LOAD_CYC = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_valid,
    output logic              o_ready,
    output logic              o_spi_clk,
    output logic              o_spi_dat,
    output logic              o_spi_load,
    input  logic              i_spi_miso,
    output logic              o_done,
    output logic [DATA_W-1:0] o_rdata,
    output state_t            o_dbg_state
);

    localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int PH_MAX = (LOAD_CYC > CLK_DIV) ? LOAD_CYC : CLK_DIV;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam logic [BIT_W-1:0] BIT_TOP   = BIT_W'(DATA_W - 1);
    localparam logic [PH_W-1:0]  LOAD_LAST = PH_W'(LOAD_CYC - 1);
    localparam logic [PH_W-1:0]  GAP_LAST  = PH_W'(CLK_DIV - 1);

    state_t            state, state_next;
    logic [DATA_W-1:0] shift_reg, shift_next;
    logic [BIT_W-1:0]  bitcnt, bitcnt_next;
    logic [PH_W-1:0]   phcnt, phcnt_next;
    logic              done_next;
    logic              done_q, dat_q, load_q;
    logic              rise, fall, sclk;

    spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk     (i_clk),
        .rst     (i_rst),
        .en      (state == SHIFT),
        .rise    (rise),
        .fall    (fall),
        .spi_clk (sclk)
    );

    always_comb begin
        state_next  = state;
        shift_next  = shift_reg;
        bitcnt_next = bitcnt;
        phcnt_next  = phcnt;
        done_next   = 1'b0;
        case (state)
            IDLE: begin
                if (i_valid) begin
                    shift_next  = i_data;
                    bitcnt_next = BIT_TOP;
                    phcnt_next  = '0;
                    state_next  = SHIFT;
                end
            end
            SHIFT: begin
                if (fall) begin
                    if (bitcnt == '0) begin
                        state_next = LOAD;
                        phcnt_next = '0;
                    end else begin
                        shift_next  = shift_reg << 1;
                        bitcnt_next = bitcnt - BIT_W'(1);
                    end
                end
            end
            LOAD: begin
                if (phcnt == LOAD_LAST) begin
                    state_next = GAP;
                    phcnt_next = '0;
                end else begin
                    phcnt_next = phcnt + PH_W'(1);
                end
            end
            GAP: begin
                if (phcnt == GAP_LAST) begin
                    state_next = IDLE;
                    phcnt_next = '0;
                    done_next  = 1'b1;
                end else begin
                    phcnt_next = phcnt + PH_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Data and load are registered from next-state so the chain never sees decode glitches.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= IDLE;
            shift_reg <= '0;
            bitcnt    <= '0;
            phcnt     <= '0;
            done_q    <= 1'b0;
            dat_q     <= 1'b0;
            load_q    <= 1'b0;
        end else begin
            state     <= state_next;
            shift_reg <= shift_next;
            bitcnt    <= bitcnt_next;
            phcnt     <= phcnt_next;
            done_q    <= done_next;
            dat_q     <= ((state_next == SHIFT) || (state_next == LOAD)) && shift_next[DATA_W-1];
            load_q    <= (state_next == LOAD);
        end
    end

    assign o_ready     = (state == IDLE);
    assign o_spi_clk   = sclk;
    assign o_spi_dat   = dat_q;
    assign o_spi_load  = load_q;
    assign o_done      = done_q;
    assign o_dbg_state = state;

`ifdef SPI_CHAIN_TX_READBACK_EN
    logic [DATA_W-1:0] rb_reg, rdata_q;

    // miso is sampled before the chain sees the rising edge, so this is its old content.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rb_reg  <= '0;
            rdata_q <= '0;
        end else begin
            if (rise) begin
                rb_reg <= {rb_reg[DATA_W-2:0], i_spi_miso};
            end
            if (done_next) begin
                rdata_q <= rb_reg;
            end
        end
    end

    assign o_rdata = rdata_q;
`else
    logic unused_sink;

    assign unused_sink = ^{i_spi_miso, rise};
    assign o_rdata     = '0;
`endif

endmodule

// File: doc/spi_chain_tx.md
Name: spi_chain_tx

Overview:
- Serial initiator (SPI-style shifter) for the on-chip SPI chain receiver.
- Takes a parallel word through a valid/ready handshake.
- Drives spi_clk, spi_dat and spi_load so that the chain latches the word.
- Used on-chip and in bench/FPGA harnesses to program the DAC data word. Optionally captures the chain's serial readback.

Parameters:
- DATA_W, 16: frame length in bits; matches the chain data width.
- CLK_DIV, 4: i_clk cycles per spi_clk half-period; legal range ≥1.
- LOAD_CYC, 2: i_clk cycles that o_spi_load is held high; legal range ≥1.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  asynchronous reset, active-high.
- i_data  in  DATA_W  word to transmit.
- i_valid  in  1  request; qualifies i_data.
- o_ready  out  1  high only in IDLE; transfer occurs when i_valid&&o_ready.
- o_spi_clk  out  1  serial clock to chain; idles low.
- o_spi_dat  out  1  serial data, MSB first.
- o_spi_load  out  1  load strobe to chain.
- i_spi_miso  in  1  chain serial output (readback).
- o_done  out  1  one-cycle pulse at end of frame.
- o_rdata  out  DATA_W  captured readback word.

Behaviour:
- Reset (async, i_rst=1):
  - state=IDLE.
  - o_ready=1; all other outputs 0, including o_rdata.
  - Shift register, bit counter and divider counter are cleared.
  - Reset asserted mid-frame aborts the frame immediately. No load pulse is produced; lines return low.
- States: IDLE → SHIFT → LOAD → GAP → IDLE.
- IDLE:
  - o_ready=1, o_spi_clk=0, o_spi_load=0.
  - On handshake at edge k: latch i_data, bitcnt=DATA_W-1, divcnt=0, enter SHIFT.
  - o_ready=0 from cycle k+1.
- SHIFT:
  - o_spi_dat = shift_reg[DATA_W-1] (MSB), valid from cycle k+1.
  - Each bit lasts 2*CLK_DIV cycles: CLK_DIV cycles with o_spi_clk=0, then CLK_DIV cycles with o_spi_clk=1.
  - First rising spi_clk edge occurs at cycle k+1+CLK_DIV, giving data CLK_DIV cycles of setup.
  - Data changes only on the falling-edge cycle, when shift_reg shifts left by 1 and bitcnt decrements.
  - After the high half of bit 0, o_spi_clk returns to 0 and the state goes to LOAD. No extra clock edge is issued.
- LOAD:
  - o_spi_load=1 for exactly LOAD_CYC cycles; o_spi_clk=0.
  - o_spi_dat holds the last bit (LSB).
- GAP:
  - All SPI lines low for CLK_DIV cycles.
  - On exit: o_done=1 for one cycle, coincident with the return to IDLE (o_ready=1 the same cycle).
- Frame occupancy, from handshake to o_ready re-high: DATA_W*2*CLK_DIV + LOAD_CYC + CLK_DIV cycles.
  - Defaults: 128+2+4 = 134 cycles.
- i_valid while busy is ignored; no queuing. i_data is sampled only at handshake.
- Back-to-back: a handshake in the o_done cycle is accepted, so the next frame starts with no additional idle cycle.
- divcnt counts 0..CLK_DIV-1 and wraps; bitcnt counts down to 0. No counter wraps at DATA_W boundaries.

Optional Feature:
- Macro: SPI_CHAIN_TX_READBACK_EN.
- Defined:
  - i_spi_miso is sampled on each spi_clk rising-edge cycle into a readback shift register (MSB first).
  - o_rdata is updated with the full word on the o_done cycle and holds until the next o_done.
  - Readback equals the chain's previous contents, as shifted out while the new word shifts in.
- Undefined:
  - o_rdata is tied to 0.
  - i_spi_miso is unused and listed in the unused-signal sink.
  - The readback register is not instantiated.

Decomposition:
- Package spi_chain_pkg:
  - state enum: IDLE, SHIFT, LOAD, GAP.
  - localparam for the default DATA_W=16.
  - function frame_cycles(DATA_W, CLK_DIV, LOAD_CYC).
- One sub-module: spi_clk_gen. It is the divider counter and produces one-cycle rise/fall tick strobes, plus the o_spi_clk level, gated by an enable from the FSM.
- The FSM and shift registers stay in spi_chain_tx.

Test Plan:
- Reset value: assert i_rst mid-SHIFT (bit 7 of 0xA5C3) → all SPI outputs 0 within the same cycle (async), o_ready=1, o_done never pulses, and the chain model keeps its old value.
- Single frame: send i_data=0xA5C3 with defaults → 16 rising spi_clk edges; bits sampled on the rising edges are 1010_0101_1100_0011; o_spi_load high exactly 2 cycles after the last falling edge; o_done at cycle k+134; the chain model o_data=0xA5C3.
- Busy ignore: pulse i_valid with 0x1234 at cycle k+10 during the 0xA5C3 frame → not accepted; the chain model ends with 0xA5C3; o_ready=0 throughout.
- Back-to-back: hold i_valid high with 0x0001 then 0xFFFF → the second handshake lands in the o_done cycle; no idle cycle between frames; two load pulses; final chain value 0xFFFF.
- Parameter corner: CLK_DIV=1, LOAD_CYC=1 → spi_clk period is 2 cycles; frame occupancy 16*2+1+1 = 34 cycles; data is stable at each rising edge.
- Readback (macro defined): preload the chain model with 0x5A5A, then send 0x0F0F → o_rdata=0x5A5A at o_done. Without the macro, o_rdata stays 0.
